// File: rtl/lfsr_pkg.sv
// Shared constants, action encoding and parity helper for the LFSR generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lfsr_pkg;

  // Maximal-length Fibonacci tap masks (bit i set => state bit i feeds the XOR).
  localparam logic [7:0]  LFSR8_TAPS  = 8'hB8;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;
  localparam logic [31:0] LFSR32_TAPS = 32'h80200003;

  // Default reset/recovery value for the 8-bit generator; any non-zero value works.
  localparam logic [7:0]  LFSR_DEFAULT_SEED = 8'hFF;

  // Widest register the generator supports.
  localparam int LFSR_MAX_WIDTH = 32;

  // What the generator does in a given cycle, resolved from load/en priority.
  typedef enum logic [2:0] {
    ACT_HOLD      = 3'd0,  // no load, no enable: everything holds
    ACT_LOAD      = 3'd1,  // runtime seed load of a non-zero value
    ACT_LOAD_ZERO = 3'd2,  // load of zero: replaced by SEED, lockup flagged
    ACT_STEP      = 3'd3,  // normal leap-forward advance
    ACT_RECOVER   = 3'd4   // advance landed on zero: replaced by SEED, lockup flagged
  } lfsr_act_e;

  // Even/odd parity of a tap-masked state; callers zero-extend to 32 bits.
  function automatic logic lfsr_parity(input logic [LFSR_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR step: shift left, feedback into bit 0.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows input continuously.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = LFSR8_TAPS
) (
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_q_nxt,
  output logic             o_fb
);

  logic [LFSR_MAX_WIDTH-1:0] w_masked;
  logic                      w_fb;

  // Only tapped bits take part in the feedback XOR.
  assign w_masked = LFSR_MAX_WIDTH'(i_q & TAPS);
  assign w_fb     = lfsr_parity(w_masked);

  // Oldest bit falls off the top, new feedback bit enters at the bottom.
  assign o_q_nxt  = {i_q[WIDTH-2:0], w_fb};
  assign o_fb     = w_fb;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised leap-forward Fibonacci LFSR with seed load, lockup recovery and wrap pulse.
// Latency: en/load sampled at an edge is visible on every output right after that edge.
// Backpressure: none; en gates advancing, load overrides en, outputs always valid.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = LFSR8_TAPS,
  parameter logic [WIDTH-1:0]  SEED  = LFSR_DEFAULT_SEED,
  parameter int                STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [STEPS-1:0] bit_out,
  output logic             lockup,
  output logic             wrap
);

  // Reject configurations that cannot produce a sensible sequence.
  if (WIDTH < 3 || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $error("lfsr_gen: TAPS must include the top state bit");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;   // value the current sequence started from
  logic [STEPS-1:0] r_bits;
  logic             r_lockup;
  logic             r_wrap;

  logic [WIDTH-1:0] w_chain [STEPS+1];
  logic [STEPS-1:0] w_fb;
  logic [WIDTH-1:0] w_adv;
  lfsr_act_e        w_act;
  logic [WIDTH-1:0] w_state_nxt;
  logic [WIDTH-1:0] w_start_nxt;
  logic [STEPS-1:0] w_bits_nxt;
  logic             w_lockup_nxt;
  logic             w_wrap_nxt;

  assign w_chain[0] = r_state;

  // Unroll STEPS single steps so one enabled cycle leaps STEPS positions ahead.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_leap
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .i_q     (w_chain[gi]),
      .o_q_nxt (w_chain[gi+1]),
      .o_fb    (w_fb[gi])
    );
  end

  assign w_adv = w_chain[STEPS];

  // Resolve load/en priority and the zero/wrap conditions into next register values.
  always_comb begin
    w_act        = ACT_HOLD;
    w_state_nxt  = r_state;
    w_start_nxt  = r_start;
    w_bits_nxt   = r_bits;
    w_lockup_nxt = 1'b0;
    w_wrap_nxt   = 1'b0;

    if (load) begin
      w_act = (load_val == '0) ? ACT_LOAD_ZERO : ACT_LOAD;
    end else if (en) begin
      w_act = (w_adv == '0) ? ACT_RECOVER : ACT_STEP;
    end

    case (w_act)
      ACT_LOAD: begin
        w_state_nxt = load_val;
        w_start_nxt = load_val;
        w_bits_nxt  = '0;
      end
      ACT_LOAD_ZERO: begin
        // An all-zero seed would lock the register forever; fall back to SEED.
        w_state_nxt  = SEED;
        w_start_nxt  = SEED;
        w_bits_nxt   = '0;
        w_lockup_nxt = 1'b1;
      end
      ACT_STEP: begin
        w_state_nxt = w_adv;
        w_bits_nxt  = w_fb;
        // Only the end-of-cycle state is compared; skipped leap states never wrap.
        w_wrap_nxt  = (w_adv == r_start);
      end
      ACT_RECOVER: begin
        // Non-maximal tap sets can fall into zero; restart the sequence from SEED.
        w_state_nxt  = SEED;
        w_start_nxt  = SEED;
        w_bits_nxt   = w_fb;
        w_lockup_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // State, start value, feedback bits and one-cycle pulses, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SEED;
      r_start  <= SEED;
      r_bits   <= '0;
      r_lockup <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_start  <= w_start_nxt;
      r_bits   <= w_bits_nxt;
      r_lockup <= w_lockup_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  assign lfsr_out = r_state;
  assign bit_out  = r_bits;
  assign lockup   = r_lockup;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 8-bit generator plus a 4-step leap instance.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_lfsr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] out1;
  logic [0:0] bits1;
  logic       lock1;
  logic       wrap1;

  logic [7:0] out4;
  logic [3:0] bits4;
  logic       lock4;
  logic       wrap4;

  int n_cmp;
  int n_err;

  lfsr_gen u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .lfsr_out (out1),
    .bit_out  (bits1),
    .lockup   (lock1),
    .wrap     (wrap1)
  );

  lfsr_gen #(.STEPS(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .lfsr_out (out4),
    .bit_out  (bits4),
    .lockup   (lock4),
    .wrap     (wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       load;
    logic       en;
    logic [7:0] lv;
    logic [7:0] exp_out;
    logic       chk_bit;
    logic       exp_bit;
    logic       exp_lock;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] seen;
    int wraps1, wraps4, wrap_at1, wrap_at4, dups, locks, nseen;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;

    // name, load, en, load_val, out, chk_bit, bit, lockup, wrap
    vecs[0]  = '{"adv1",      1'b0, 1'b1, 8'h00, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"adv2",      1'b0, 1'b1, 8'h00, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"adv3",      1'b0, 1'b1, 8'h00, 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"adv4",      1'b0, 1'b1, 8'h00, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"adv5",      1'b0, 1'b1, 8'h00, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"load00",    1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"load01",    1'b1, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"adv01",     1'b0, 1'b1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"load_en5A", 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"hold1",     1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"hold2",     1'b0, 1'b0, 8'h33, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"adv5A",     1'b0, 1'b1, 8'h00, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state of both instances.
    tick();
    chk("rst_out1",  32'(out1),  32'hFF);
    chk("rst_bit1",  32'(bits1), 32'h0);
    chk("rst_lock1", 32'(lock1), 32'h0);
    chk("rst_wrap1", 32'(wrap1), 32'h0);
    chk("rst_out4",  32'(out4),  32'hFF);
    chk("rst_bit4",  32'(bits4), 32'h0);
    #2 rst = 1'b0;

    // Leap-forward by 4: FF -> F0 -> 0B (feedback bits 0,0,0,0 then 1,0,1,1).
    en = 1'b1;
    tick();
    chk("s4_out_a", 32'(out4),  32'hF0);
    chk("s4_bit_a", 32'(bits4), 32'h0);
    chk("s1_out_a", 32'(out1),  32'hFE);
    tick();
    chk("s4_out_b", 32'(out4),  32'h0B);
    chk("s4_bit_b", 32'(bits4), 32'hD);
    chk("s1_out_b", 32'(out1),  32'hFC);

    // Asynchronous reset between edges: outputs return to reset values with no clock.
    #2 rst = 1'b1;
    #1;
    chk("arst_out1",  32'(out1),  32'hFF);
    chk("arst_bit1",  32'(bits1), 32'h0);
    chk("arst_lock1", 32'(lock1), 32'h0);
    chk("arst_wrap1", 32'(wrap1), 32'h0);
    chk("arst_out4",  32'(out4),  32'hFF);
    chk("arst_bit4",  32'(bits4), 32'h0);
    #1 rst = 1'b0;

    // Directed vector table; the first row also shows the restart at FE.
    for (int i = 0; i < 12; i++) begin
      load     = vecs[i].load;
      en       = vecs[i].en;
      load_val = vecs[i].lv;
      tick();
      chk({vecs[i].name, "_out"},  32'(out1),  32'(vecs[i].exp_out));
      if (vecs[i].chk_bit)
        chk({vecs[i].name, "_bit"}, 32'(bits1), 32'(vecs[i].exp_bit));
      chk({vecs[i].name, "_lock"}, 32'(lock1), 32'(vecs[i].exp_lock));
      chk({vecs[i].name, "_wrap"}, 32'(wrap1), 32'(vecs[i].exp_wrap));
    end

    // Full period from reset: every non-zero value once, single wrap on the 255th advance.
    load = 1'b0;
    en   = 1'b0;
    rst  = 1'b1;
    tick();
    rst      = 1'b0;
    en       = 1'b1;
    seen     = '0;
    wraps1   = 0;
    wraps4   = 0;
    wrap_at1 = 0;
    wrap_at4 = 0;
    dups     = 0;
    locks    = 0;
    for (int c = 1; c <= 255; c++) begin
      tick();
      if (seen[out1]) dups++;
      seen[out1] = 1'b1;
      if (wrap1) begin wraps1++; wrap_at1 = c; end
      if (wrap4) begin wraps4++; wrap_at4 = c; end
      if (lock1 || lock4) locks++;
    end
    nseen = $countones(seen);
    chk("per_wraps1",  32'(wraps1),   32'd1);
    chk("per_wrapat1", 32'(wrap_at1), 32'd255);
    chk("per_out1",    32'(out1),     32'hFF);
    chk("per_dups",    32'(dups),     32'd0);
    chk("per_nseen",   32'(nseen),    32'd255);
    chk("per_zero",    32'(seen[0]),  32'd0);
    chk("per_locks",   32'(locks),    32'd0);
    chk("per_wraps4",  32'(wraps4),   32'd1);
    chk("per_wrapat4", 32'(wrap_at4), 32'd255);
    chk("per_out4",    32'(out4),     32'hFF);

    // Wrap is a single-cycle pulse; the sequence simply carries on.
    tick();
    chk("post_wrap1", 32'(wrap1), 32'h0);
    chk("post_out1",  32'(out1),  32'hFE);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
